sn74hc595_trio_seg8_receiver: RTL and testbench
===============================================

# sn74hc595_trio_seg8_receiver

Receive-side counterpart of the three-digit 74HC595 segment driver. Samples the driver's `clk_serial` / `data` / `load` pins in the system clock domain and emulates a cascade of three 74HC595s (24-bit shift register plus storage latch). It decodes each latched 8-bit segment pattern back to a hex digit. Used as a bus monitor and scoreboard front-end in driver benches, and as an in-FPGA loopback checker.

## Interface

Parameters:
- `COMMON_ANODE`, default 0: 1 means segment patterns are active-low, and each byte is inverted before storage and decode.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clk_serial`  in  1  shift clock from the driver; asynchronous, idle low.
- `data`  in  1  serial data from the driver; asynchronous.
- `load`  in  1  storage-latch strobe from the driver; asynchronous, idle low.
- `seg0`, `seg1`, `seg2`  out  8  latched segment patterns, normalized active-high, bit order {dp,g,f,e,d,c,b,a}.
- `digit0`, `digit1`, `digit2`  out  4  decoded hex value of each pattern.
- `digit_ok`  out  3  bit i is 1 if `seg`i[6:0] matches a hex glyph.
- `frame_valid`  out  1  one-cycle pulse when a 24-bit frame is latched.
- `frame_err`  out  1  one-cycle pulse when a latch occurs with a bit count other than 24.

## Operation

- **Synchronizers.** `clk_serial`, `data` and `load` each pass through a 2-flop synchronizer that resets to 0. A third register per line holds the previous synchronized value.
- **Edge detection.** A rising edge means the synchronized value is 1 and the previous value is 0.
- **Shift.**
  - On a `clk_serial` rising edge: `sr <= {sr[22:0], data_sync}`, taking MSB first.
  - The 5-bit bit counter increments and saturates at 25.
- **Frame mapping after 24 shifts.** The first byte shifted in sits in `sr[23:16]` and maps to digit 2. `sr[15:8]` maps to digit 1 and `sr[7:0]` to digit 0.
- **Latch.** On a `load` rising edge:
  - Each `seg`i takes the matching byte of `sr`, XORed with 8'hFF when `COMMON_ANODE` is 1.
  - `digit`i and `digit_ok` update in the same cycle from the decoded bytes.
  - If count == 24, pulse `frame_valid`; otherwise pulse `frame_err`. The latch always happens, as on real hardware.
  - The counter clears to 0.
  - `sr` is not cleared, matching 74HC595 behaviour.
- **Decode.** The decode ignores dp (bit 7). Glyph table for 0-F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71. A non-matching pattern gives digit = 0 and ok = 0.
- **Simultaneous shift and load edges.** The shift is applied first. The latch captures the post-shift value, and that bit is included in the count.

## Timing

- **Reset values.** While `rst` is high, or after it, all outputs are 0: `seg*`, `digit*`, `digit_ok`, `frame_valid`, `frame_err`. The internal state `sr`, the counter and all synchronizer flops are also 0.
- **Latency.** The pin `load` is first sampled high at edge k. Outputs and the pulse are registered at edge k+2, so they are visible after that edge. The shift path has the same 2-cycle latency. Data and clock are delayed equally, so data aligns with its shift edge.
- **Input constraints.**
  - `clk_serial` must be high ≥2 and low ≥2 `clk` periods.
  - `data` must be stable ≥2 `clk` periods before and ≥1 after each `clk_serial` rise.
  - `load` must be high ≥2 periods.
  - Narrower pulses are undefined.
- **Pulses.** `frame_valid` and `frame_err` are exactly one cycle wide and mutually exclusive.
- **Reset mid-frame.** Partial bits are discarded and the counter returns to 0. A later `load` without 24 new bits gives `frame_err`.

## Structure

- **Package `sn74hc595_seg8_pkg`:**
  - `FRAME_BITS` = 24 and `SEG_W` = 8.
  - The 16-entry glyph constant table.
  - The bit-position constants for dp and a-g.
- **Sub-module `seg8_glyph_decoder`:** combinational, 8-bit pattern in, 4-bit digit and ok out. Instantiated three times.
- All sequential logic stays in the top module: synchronizers, edge detectors, shift register, counter and output registers.

## Test plan

- **Nominal frame.** Serial frame for digits 2/1/0 = 5/4/3 (bytes 6D, 66, 4F), then `load`. Expect `digit2`..0 = 5,4,3, `digit_ok` = 3'b111, one `frame_valid` at load+2, and `frame_err` = 0.
- **Short frame.** 16 bits then `load`. Expect `frame_err` pulse, no `frame_valid`, and `seg`* updated with the shifted content.
- **Non-glyph pattern.** Frame with byte 0 = 8'h00 and byte 1 = 8'h80 (dp only). Expect `digit_ok` = 3'b100, and `digit0` = `digit1` = 0.
- **Reset mid-frame.** Reset after 10 bits, then a full 24-bit frame of 8/8/8 (7F ×3) plus `load`. Expect `frame_valid`, all digits 8, and all outputs 0 during reset.
- **Common anode.** `COMMON_ANODE` = 1, bytes C0/F9/A4. Expect `seg2`..0 = 3F/06/5B and digits 0/1/2.
- **Back-to-back frames.** Two consecutive frames (A/b/C then d/E/F) with minimum spacing. Expect two `frame_valid` pulses with correct digits each time, and a counter that never reports an error.

Source files
------------

// File: rtl/sn74hc595_seg8_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Package     : sn74hc595_seg8_pkg
//  Description : Shared constants for the 74HC595 trio segment receiver.
//                Holds the frame/byte widths, the segment bit positions
//                and the hex glyph table, with index 0 in the LSB slot.
//  Revision    : 1.0  initial release
// ============================================================================
package sn74hc595_seg8_pkg;

    localparam int FRAME_BITS = 24;
    localparam int SEG_W      = 8;

    // Segment bit positions, byte order {dp,g,f,e,d,c,b,a}
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high glyphs for 0..F; entry i is GLYPH_TABLE[i]
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage : sn74hc595_seg8_pkg
`default_nettype wire

// File: rtl/seg8_glyph_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : seg8_glyph_decoder
//  Description : Combinational 7-segment pattern to hex digit decoder.
//                The dp bit is ignored. Patterns matching no glyph give
//                digit 0 with ok low.
//  Ports       : seg_i   [7:0] active-high pattern {dp,g,f,e,d,c,b,a}
//                digit_o [3:0] decoded hex value
//                ok_o          pattern matched a glyph
//  Revision    : 1.0  initial release
// ============================================================================
module seg8_glyph_decoder
    import sn74hc595_seg8_pkg::*;
(
    input  logic [SEG_W-1:0] seg_i,
    output logic [3:0]       digit_o,
    output logic             ok_o
);

    always_comb begin
        digit_o = 4'd0;
        ok_o    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i[SEG_G:SEG_A] == GLYPH_TABLE[i[3:0]]) begin
                digit_o = i[3:0];
                ok_o    = 1'b1;
            end
        end
    end

endmodule : seg8_glyph_decoder
`default_nettype wire

// File: rtl/sn74hc595_trio_seg8_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sn74hc595_trio_seg8_receiver
//  Description : Emulates a cascade of three 74HC595s driven by asynchronous
//                clk_serial/data/load pins, and decodes the latched bytes
//                back to hex digits.
//  Ports       : clk, rst             system clock, async active-high reset
//                clk_serial,data,load asynchronous driver pins
//                seg0..seg2    [7:0]  latched patterns, active-high
//                digit0..digit2[3:0]  decoded hex values
//                digit_ok      [2:0]  per-digit glyph match
//                frame_valid          1-cycle pulse, latch after 24 bits
//                frame_err            1-cycle pulse, latch with other count
//  Revision    : 1.0  initial release
// ============================================================================
module sn74hc595_trio_seg8_receiver
    import sn74hc595_seg8_pkg::*;
#(
    parameter bit COMMON_ANODE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_serial,
    input  logic             data,
    input  logic             load,
    output logic [SEG_W-1:0] seg0,
    output logic [SEG_W-1:0] seg1,
    output logic [SEG_W-1:0] seg2,
    output logic [3:0]       digit0,
    output logic [3:0]       digit1,
    output logic [3:0]       digit2,
    output logic [2:0]       digit_ok,
    output logic             frame_valid,
    output logic             frame_err
);

    localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
    localparam logic [4:0] CNT_SAT  = 5'(FRAME_BITS + 1);

    // Lane order in the synchronizer vectors: 0 clk_serial, 1 data, 2 load
    logic [2:0]            sync1_q, sync2_q, prev_q;
    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic [4:0]            cnt_q, cnt_d, cnt_shifted;
    logic [2:0][SEG_W-1:0] seg_q;
    logic [2:0][3:0]       digit_q;
    logic [2:0]            ok_q;
    logic                  valid_q, err_q;

    logic                  shift_edge, load_edge;
    logic [2:0][SEG_W-1:0] byte_d;
    logic [2:0][3:0]       dec_digit;
    logic [2:0]            dec_ok;

    assign shift_edge = sync2_q[0] & ~prev_q[0];
    assign load_edge  = sync2_q[2] & ~prev_q[2];

    // Shift is applied before a coincident latch, so the latch sees the
    // post-shift register and the post-shift count.
    always_comb begin
        sr_d        = sr_q;
        cnt_shifted = cnt_q;
        if (shift_edge) begin
            sr_d = {sr_q[FRAME_BITS-2:0], sync2_q[1]};
            if (cnt_q != CNT_SAT) begin
                cnt_shifted = cnt_q + 5'd1;
            end
        end
        cnt_d = load_edge ? 5'd0 : cnt_shifted;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dec
            assign byte_d[gi] = sr_d[gi*SEG_W +: SEG_W] ^ {SEG_W{COMMON_ANODE}};
            seg8_glyph_decoder u_dec (
                .seg_i   (byte_d[gi]),
                .digit_o (dec_digit[gi]),
                .ok_o    (dec_ok[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            seg_q   <= '0;
            digit_q <= '0;
            ok_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= {load, data, clk_serial};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            valid_q <= load_edge && (cnt_shifted == CNT_FULL);
            err_q   <= load_edge && (cnt_shifted != CNT_FULL);
            if (load_edge) begin
                seg_q   <= byte_d;
                digit_q <= dec_digit;
                ok_q    <= dec_ok;
            end
        end
    end

    assign seg0        = seg_q[0];
    assign seg1        = seg_q[1];
    assign seg2        = seg_q[2];
    assign digit0      = digit_q[0];
    assign digit1      = digit_q[1];
    assign digit2      = digit_q[2];
    assign digit_ok    = ok_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;

endmodule : sn74hc595_trio_seg8_receiver
`default_nettype wire

// File: tb/tb_sn74hc595_trio_seg8_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sn74hc595_trio_seg8_receiver
//  Description : Scoreboard bench. Two receivers (common cathode and common
//                anode) watch the same pins; a reference model built from
//                the shifted-bit history predicts every latch.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sn74hc595_trio_seg8_receiver;

    logic clk = 1'b0;
    logic rst, clk_serial, data, load;

    logic [7:0] cc_seg [3];
    logic [7:0] ca_seg [3];
    logic [3:0] cc_dig [3];
    logic [3:0] ca_dig [3];
    logic [2:0] cc_ok, ca_ok;
    logic       cc_fv, cc_fe, ca_fv, ca_fe;

    sn74hc595_trio_seg8_receiver #(.COMMON_ANODE(1'b0)) dut_cc (
        .clk(clk), .rst(rst), .clk_serial(clk_serial), .data(data), .load(load),
        .seg0(cc_seg[0]), .seg1(cc_seg[1]), .seg2(cc_seg[2]),
        .digit0(cc_dig[0]), .digit1(cc_dig[1]), .digit2(cc_dig[2]),
        .digit_ok(cc_ok), .frame_valid(cc_fv), .frame_err(cc_fe)
    );

    sn74hc595_trio_seg8_receiver #(.COMMON_ANODE(1'b1)) dut_ca (
        .clk(clk), .rst(rst), .clk_serial(clk_serial), .data(data), .load(load),
        .seg0(ca_seg[0]), .seg1(ca_seg[1]), .seg2(ca_seg[2]),
        .digit0(ca_dig[0]), .digit1(ca_dig[1]), .digit2(ca_dig[2]),
        .digit_ok(ca_ok), .frame_valid(ca_fv), .frame_err(ca_fe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [2:0][7:0] seg;
        logic [2:0][3:0] dig;
        logic [2:0]      ok;
        logic            valid;
        logic [31:0]     due;
    } exp_t;

    exp_t exp_cc[$];
    exp_t exp_ca[$];

    logic [6:0] GTAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    bit hist[$];      // every bit shifted since reset, oldest first
    int nbits = 0;    // bits shifted since last latch or reset

    task automatic decode(input logic [7:0] s, output logic [3:0] d, output logic ok);
        d  = 4'd0;
        ok = 1'b0;
        for (int i = 0; i < 16; i++)
            if (s[6:0] == GTAB[i]) begin
                d  = i[3:0];
                ok = 1'b1;
            end
    endtask

    task automatic model_shift(input bit b);
        hist.push_back(b);
        nbits++;
    endtask

    // The 24-bit register holds the last 24 bits shifted; first of them is
    // the MSB (digit 2). Missing history reads as the reset value 0.
    task automatic model_latch();
        exp_t e_cc, e_ca;
        logic [23:0] srv;
        int n = hist.size();
        for (int j = 0; j < 24; j++) srv[j] = (j < n) ? hist[n-1-j] : 1'b0;
        for (int d = 0; d < 3; d++) begin
            e_cc.seg[d] = srv[8*d +: 8];
            e_ca.seg[d] = srv[8*d +: 8] ^ 8'hFF;
            decode(e_cc.seg[d], e_cc.dig[d], e_cc.ok[d]);
            decode(e_ca.seg[d], e_ca.dig[d], e_ca.ok[d]);
        end
        e_cc.valid = (nbits == 24);
        e_ca.valid = (nbits == 24);
        e_cc.due   = cyc + 3;
        e_ca.due   = cyc + 3;
        exp_cc.push_back(e_cc);
        exp_ca.push_back(e_ca);
        nbits = 0;
    endtask

    // ---------------- stimulus ----------------
    task automatic send_bit(input bit b, input bit with_load);
        @(negedge clk);
        data = b;
        repeat (2) @(negedge clk);
        clk_serial = 1'b1;
        model_shift(b);
        if (with_load) begin
            load = 1'b1;
            model_latch();
        end
        repeat (2) @(negedge clk);
        clk_serial = 1'b0;
        load       = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i], 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] b2, input logic [7:0] b1, input logic [7:0] b0);
        send_byte(b2);
        send_byte(b1);
        send_byte(b0);
    endtask

    task automatic pulse_load();
        @(negedge clk);
        load = 1'b1;
        model_latch();
        repeat (2) @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_cc_seg"}, {8'h0, cc_seg[2], cc_seg[1], cc_seg[0]}, 32'h0);
        chk({tag, "_ca_seg"}, {8'h0, ca_seg[2], ca_seg[1], ca_seg[0]}, 32'h0);
        chk({tag, "_cc_dig"}, {20'h0, cc_dig[2], cc_dig[1], cc_dig[0]}, 32'h0);
        chk({tag, "_ca_dig"}, {20'h0, ca_dig[2], ca_dig[1], ca_dig[0]}, 32'h0);
        chk({tag, "_flags"}, {20'h0, cc_ok, ca_ok, cc_fv, cc_fe, ca_fv, ca_fe}, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        hist.delete();
        nbits = 0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    task automatic compare(input string who, input exp_t e,
                           input logic [23:0] seg, input logic [11:0] dig,
                           input logic [2:0] ok, input logic fv, input logic fe);
        chk({who, "_seg"},   {8'h0, seg}, {8'h0, e.seg});
        chk({who, "_digit"}, {20'h0, dig}, {20'h0, e.dig});
        chk({who, "_ok"},    {29'h0, ok}, {29'h0, e.ok});
        chk({who, "_valid"}, {31'h0, fv}, {31'h0, e.valid});
        chk({who, "_err"},   {31'h0, fe}, {31'h0, ~e.valid});
        chk({who, "_latency"}, cyc, e.due);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (cc_fv | cc_fe) begin
                if (exp_cc.size() == 0) chk("cc_unexpected_pulse", {31'h0, cc_fv | cc_fe}, 32'h0);
                else compare("cc", exp_cc.pop_front(), {cc_seg[2], cc_seg[1], cc_seg[0]},
                             {cc_dig[2], cc_dig[1], cc_dig[0]}, cc_ok, cc_fv, cc_fe);
            end
            if (ca_fv | ca_fe) begin
                if (exp_ca.size() == 0) chk("ca_unexpected_pulse", {31'h0, ca_fv | ca_fe}, 32'h0);
                else compare("ca", exp_ca.pop_front(), {ca_seg[2], ca_seg[1], ca_seg[0]},
                             {ca_dig[2], ca_dig[1], ca_dig[0]}, ca_ok, ca_fv, ca_fe);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin
        int len;
        logic [7:0] b [3];
        rst = 1'b1; clk_serial = 1'b0; data = 1'b0; load = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("initial");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // nominal 5/4/3
        send_frame(8'h6D, 8'h66, 8'h4F);
        pulse_load();

        // short frame: 16 bits
        send_byte(8'h5B);
        send_byte(8'h07);
        pulse_load();

        // non-glyph bytes in digits 0 and 1
        send_frame(8'h06, 8'h80, 8'h00);
        pulse_load();

        // reset mid-frame, then 8/8/8
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        do_reset();
        send_frame(8'h7F, 8'h7F, 8'h7F);
        pulse_load();

        // load after reset with no new bits
        do_reset();
        pulse_load();

        // common-anode encoded 0/1/2
        send_frame(8'hC0, 8'hF9, 8'hA4);
        pulse_load();

        // back-to-back A/b/C then d/E/F
        send_frame(8'h77, 8'h7C, 8'h39);
        pulse_load();
        send_frame(8'h5E, 8'h79, 8'h71);
        pulse_load();

        // 24th bit coincident with load
        send_byte(8'h4F);
        send_byte(8'h66);
        for (int i = 7; i >= 1; i--) send_bit(1'(8'h6D >> i), 1'b0);
        send_bit(1'b1, 1'b1);
        repeat (4) @(negedge clk);

        // 56 bits: counter must saturate rather than wrap to 24
        for (int i = 0; i < 56; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        pulse_load();

        // randomized frames
        for (int f = 0; f < 20; f++) begin
            for (int d = 0; d < 3; d++) begin
                if ($urandom_range(0, 5) == 0) b[d] = 8'($urandom);
                else b[d] = {1'($urandom_range(0, 1)), GTAB[$urandom_range(0, 15)]};
            end
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : 24;
            for (int i = 0; i < len; i++) begin
                logic [23:0] fr;
                fr = {b[2], b[1], b[0]};
                if (i == len - 1 && $urandom_range(0, 2) == 0) begin
                    send_bit(fr[(23 - i) % 24], 1'b1);
                    repeat (3) @(negedge clk);
                end else begin
                    send_bit(fr[(23 - i) % 24], 1'b0);
                    if (i == len - 1) pulse_load();
                end
            end
            if (len == 0) pulse_load();
        end

        for (int i = 0; i < 50 && (exp_cc.size() != 0 || exp_ca.size() != 0); i++) @(negedge clk);
        chk("cc_queue_drained", exp_cc.size(), 32'h0);
        chk("ca_queue_drained", exp_ca.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sn74hc595_trio_seg8_receiver
`default_nettype wire
